// File: rtl/sram_arb_pkg.sv
// Shared types for sram_like_arbiter: FSM states, grant owner, access sizes.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } grant_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One sram-like channel: request fields from master, handshakes and read data from slave.
interface sram_like_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter_pick.sv
// Winner selection between inst and data requests.
// SRAM_ARB_ROUND_ROBIN_EN: ties alternate using last_grant; otherwise DATA wins ties.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic   inst_req,
  input  logic   data_req,
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  input  grant_e last_grant,
`endif
  output logic   valid,
  output grant_e winner
);

  always_comb begin
    valid  = inst_req | data_req;
    winner = DATA;
    if (inst_req && data_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      winner = (last_grant == DATA) ? INST : DATA;
`else
      winner = DATA;
`endif
    end else if (inst_req) begin
      winner = INST;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) to one-slave sram-like arbiter, one outstanding transaction.
// Tie policy selected by SRAM_ARB_ROUND_ROBIN_EN (default: fixed DATA priority).
module sram_like_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  sram_like_arbiter_if.slave  inst,
  sram_like_arbiter_if.slave  data,
  sram_like_arbiter_if.master mem
);

  state_e            state_q, state_d;
  grant_e            grant_q;
  grant_e            win;
  logic              win_valid;
  logic              accept;
  logic              resp;

  logic              wr_q;
  logic [1:0]        size_q;
  logic [3:0]        wstrb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  grant_e            last_grant_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= DATA;
    end else if (accept) begin
      last_grant_q <= win;
    end
  end

  sram_arb_pick u_pick (
    .inst_req   (inst.req),
    .data_req   (data.req),
    .last_grant (last_grant_q),
    .valid      (win_valid),
    .winner     (win)
  );
`else
  sram_arb_pick u_pick (
    .inst_req (inst.req),
    .data_req (data.req),
    .valid    (win_valid),
    .winner   (win)
  );
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // resetn gates acceptance so addr_ok is low throughout reset even with a request held.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    resp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid && resetn) begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem.addr_ok) state_d = RESP;
      end
      RESP: begin
        if (mem.data_ok) begin
          resp    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_q <= DATA;
      wr_q    <= 1'b0;
      size_q  <= '0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      grant_q <= win;
      if (win == INST) begin
        wr_q    <= inst.wr;
        size_q  <= inst.size;
        wstrb_q <= inst.wstrb;
        addr_q  <= inst.addr;
        wdata_q <= inst.wdata;
      end else begin
        wr_q    <= data.wr;
        size_q  <= data.size;
        wstrb_q <= data.wstrb;
        addr_q  <= data.addr;
        wdata_q <= data.wdata;
      end
    end
  end

  assign inst.addr_ok = accept && (win == INST);
  assign data.addr_ok = accept && (win == DATA);
  assign inst.data_ok = resp && (grant_q == INST);
  assign data.data_ok = resp && (grant_q == DATA);
  assign inst.rdata   = (resp && (grant_q == INST)) ? mem.rdata : '0;
  assign data.rdata   = (resp && (grant_q == DATA)) ? mem.rdata : '0;

  assign mem.req   = (state_q == REQ);
  assign mem.wr    = wr_q;
  assign mem.size  = size_q;
  assign mem.wstrb = wstrb_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter; tie expectations follow SRAM_ARB_ROUND_ROBIN_EN.
module tb_sram_like_arbiter;
  import sram_arb_pkg::*;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_bus ();
  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_bus ();
  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .inst   (inst_bus.slave),
    .data   (data_bus.slave),
    .mem    (mem_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_bus.req = 0; inst_bus.wr = 0; inst_bus.size = SIZE_W; inst_bus.wstrb = 4'hF;
    inst_bus.addr = '0; inst_bus.wdata = '0;
    data_bus.req = 0; data_bus.wr = 0; data_bus.size = SIZE_W; data_bus.wstrb = 4'hF;
    data_bus.addr = '0; data_bus.wdata = '0;
    mem_bus.addr_ok = 0; mem_bus.data_ok = 0; mem_bus.rdata = '0;
  endtask

  task automatic test_reset();
    resetn = 0;
    clear_inputs();
    inst_bus.req = 1; data_bus.req = 1;
    step();
    checks++; if (mem_bus.req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_bus.req); end
    checks++; if (inst_bus.addr_ok !== 1'b0) begin errors++; $display("FAIL reset_inst_addr_ok: got %b expected 0", inst_bus.addr_ok); end
    checks++; if (data_bus.addr_ok !== 1'b0) begin errors++; $display("FAIL reset_data_addr_ok: got %b expected 0", data_bus.addr_ok); end
    checks++; if (mem_bus.addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_bus.addr); end
    clear_inputs();
    step();
    resetn = 1;
    step();
  endtask

  task automatic test_tie();
    logic first_inst;
    logic w_addr_ok, l_addr_ok, w_data_ok, l_data_ok;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    first_inst = 1'b1;
`else
    first_inst = 1'b0;
`endif
    inst_bus.req = 1; inst_bus.addr = 32'h300;
    data_bus.req = 1; data_bus.addr = 32'h200;
    #1;
    w_addr_ok = first_inst ? inst_bus.addr_ok : data_bus.addr_ok;
    l_addr_ok = first_inst ? data_bus.addr_ok : inst_bus.addr_ok;
    checks++; if (w_addr_ok !== 1'b1) begin errors++; $display("FAIL tie1_winner_addr_ok: got %b expected 1", w_addr_ok); end
    checks++; if (l_addr_ok !== 1'b0) begin errors++; $display("FAIL tie1_loser_addr_ok: got %b expected 0", l_addr_ok); end
    step();
    if (first_inst) inst_bus.req = 0; else data_bus.req = 0;
    mem_bus.addr_ok = 1;
    #1;
    checks++; if (mem_bus.addr !== (first_inst ? 32'h300 : 32'h200)) begin errors++; $display("FAIL tie1_mem_addr: got %h expected %h", mem_bus.addr, first_inst ? 32'h300 : 32'h200); end
    step();
    mem_bus.addr_ok = 0; mem_bus.data_ok = 1; mem_bus.rdata = 32'hD0D0_0001;
    #1;
    w_data_ok = first_inst ? inst_bus.data_ok : data_bus.data_ok;
    l_addr_ok = first_inst ? data_bus.addr_ok : inst_bus.addr_ok;
    checks++; if (w_data_ok !== 1'b1) begin errors++; $display("FAIL tie1_winner_data_ok: got %b expected 1", w_data_ok); end
    checks++; if (l_addr_ok !== 1'b0) begin errors++; $display("FAIL tie1_loser_wait: got %b expected 0", l_addr_ok); end
    step();
    mem_bus.data_ok = 0;
    #1;
    l_addr_ok = first_inst ? data_bus.addr_ok : inst_bus.addr_ok;
    checks++; if (l_addr_ok !== 1'b1) begin errors++; $display("FAIL tie1_loser_addr_ok: got %b expected 1", l_addr_ok); end
    step();
    inst_bus.req = 0; data_bus.req = 0; mem_bus.addr_ok = 1;
    #1;
    checks++; if (mem_bus.addr !== (first_inst ? 32'h200 : 32'h300)) begin errors++; $display("FAIL tie1_second_addr: got %h expected %h", mem_bus.addr, first_inst ? 32'h200 : 32'h300); end
    step();
    mem_bus.addr_ok = 0; mem_bus.data_ok = 1; mem_bus.rdata = 32'hD0D0_0002;
    #1;
    l_data_ok = first_inst ? data_bus.data_ok : inst_bus.data_ok;
    checks++; if (l_data_ok !== 1'b1) begin errors++; $display("FAIL tie1_loser_data_ok: got %b expected 1", l_data_ok); end
    step();
    mem_bus.data_ok = 0;
    // Second tie: round robin now favours INST again; fixed priority stays with DATA.
    inst_bus.req = 1; data_bus.req = 1;
    #1;
    checks++; if (inst_bus.addr_ok !== first_inst) begin errors++; $display("FAIL tie2_inst_addr_ok: got %b expected %b", inst_bus.addr_ok, first_inst); end
    checks++; if (data_bus.addr_ok !== !first_inst) begin errors++; $display("FAIL tie2_data_addr_ok: got %b expected %b", data_bus.addr_ok, !first_inst); end
    step();
    inst_bus.req = 0; data_bus.req = 0; mem_bus.addr_ok = 1;
    step();
    mem_bus.addr_ok = 0; mem_bus.data_ok = 1;
    step();
    clear_inputs();
  endtask

  task automatic test_single_inst_read();
    inst_bus.req = 1; inst_bus.wr = 0; inst_bus.size = SIZE_W; inst_bus.addr = 32'h1c00_0000;
    #1;
    checks++; if (inst_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL rd_inst_addr_ok: got %b expected 1", inst_bus.addr_ok); end
    checks++; if (mem_bus.req !== 1'b0) begin errors++; $display("FAIL rd_mem_req_T: got %b expected 0", mem_bus.req); end
    step();
    inst_bus.req = 0; inst_bus.addr = 32'hDEAD_BEEF; mem_bus.addr_ok = 1;
    #1;
    checks++; if (mem_bus.req !== 1'b1) begin errors++; $display("FAIL rd_mem_req_T1: got %b expected 1", mem_bus.req); end
    checks++; if (mem_bus.addr !== 32'h1c00_0000) begin errors++; $display("FAIL rd_mem_addr: got %h expected 1c000000", mem_bus.addr); end
    checks++; if (mem_bus.wr !== 1'b0) begin errors++; $display("FAIL rd_mem_wr: got %b expected 0", mem_bus.wr); end
    checks++; if (inst_bus.data_ok !== 1'b0) begin errors++; $display("FAIL rd_early_data_ok: got %b expected 0", inst_bus.data_ok); end
    step();
    mem_bus.addr_ok = 0; mem_bus.data_ok = 1; mem_bus.rdata = 32'h1234_5678;
    #1;
    checks++; if (inst_bus.data_ok !== 1'b1) begin errors++; $display("FAIL rd_inst_data_ok: got %b expected 1", inst_bus.data_ok); end
    checks++; if (inst_bus.rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_inst_rdata: got %h expected 12345678", inst_bus.rdata); end
    checks++; if (data_bus.data_ok !== 1'b0) begin errors++; $display("FAIL rd_data_data_ok: got %b expected 0", data_bus.data_ok); end
    checks++; if (data_bus.rdata !== 32'h0) begin errors++; $display("FAIL rd_data_rdata: got %h expected 0", data_bus.rdata); end
    checks++; if (mem_bus.req !== 1'b0) begin errors++; $display("FAIL rd_mem_req_resp: got %b expected 0", mem_bus.req); end
    step();
    clear_inputs();
    #1;
    checks++; if (inst_bus.data_ok !== 1'b0) begin errors++; $display("FAIL rd_data_ok_after: got %b expected 0", inst_bus.data_ok); end
  endtask

  task automatic test_write_stall();
    data_bus.req = 1; data_bus.wr = 1; data_bus.size = SIZE_H; data_bus.wstrb = 4'b0011;
    data_bus.addr = 32'h100; data_bus.wdata = 32'hAABB_CCDD;
    #1;
    checks++; if (data_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL wr_addr_ok: got %b expected 1", data_bus.addr_ok); end
    step();
    data_bus.req = 0; data_bus.wr = 0; data_bus.wstrb = 4'hC; data_bus.addr = 32'h9999; data_bus.wdata = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (mem_bus.req !== 1'b1) begin errors++; $display("FAIL wr_stall_req[%0d]: got %b expected 1", i, mem_bus.req); end
      checks++; if (mem_bus.addr !== 32'h100) begin errors++; $display("FAIL wr_stall_addr[%0d]: got %h expected 100", i, mem_bus.addr); end
      checks++; if (mem_bus.wstrb !== 4'b0011) begin errors++; $display("FAIL wr_stall_wstrb[%0d]: got %b expected 0011", i, mem_bus.wstrb); end
      checks++; if (mem_bus.wdata !== 32'hAABB_CCDD) begin errors++; $display("FAIL wr_stall_wdata[%0d]: got %h expected aabbccdd", i, mem_bus.wdata); end
      checks++; if (mem_bus.wr !== 1'b1 || mem_bus.size !== SIZE_H) begin errors++; $display("FAIL wr_stall_wr_size[%0d]: got %b/%0d expected 1/1", i, mem_bus.wr, mem_bus.size); end
      step();
    end
    mem_bus.addr_ok = 1;
    step();
    mem_bus.addr_ok = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (data_bus.data_ok !== 1'b0) begin errors++; $display("FAIL wr_resp_stall[%0d]: got %b expected 0", i, data_bus.data_ok); end
      step();
    end
    mem_bus.data_ok = 1;
    #1;
    checks++; if (data_bus.data_ok !== 1'b1) begin errors++; $display("FAIL wr_data_ok: got %b expected 1", data_bus.data_ok); end
    checks++; if (inst_bus.data_ok !== 1'b0) begin errors++; $display("FAIL wr_inst_data_ok: got %b expected 0", inst_bus.data_ok); end
    step();
    clear_inputs();
  endtask

  task automatic test_spurious();
    mem_bus.data_ok = 1; mem_bus.rdata = 32'h5555_AAAA;
    #1;
    checks++; if (inst_bus.data_ok !== 1'b0 || data_bus.data_ok !== 1'b0) begin errors++; $display("FAIL spur_idle_data_ok: got %b%b expected 00", inst_bus.data_ok, data_bus.data_ok); end
    step();
    mem_bus.data_ok = 0; inst_bus.req = 1; inst_bus.addr = 32'h44;
    #1;
    checks++; if (inst_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL spur_still_idle: got %b expected 1", inst_bus.addr_ok); end
    step();
    inst_bus.req = 0; mem_bus.data_ok = 1;
    #1;
    checks++; if (inst_bus.data_ok !== 1'b0) begin errors++; $display("FAIL spur_req_data_ok: got %b expected 0", inst_bus.data_ok); end
    step();
    mem_bus.data_ok = 0;
    #1;
    checks++; if (mem_bus.req !== 1'b1) begin errors++; $display("FAIL spur_still_req: got %b expected 1", mem_bus.req); end
    mem_bus.addr_ok = 1;
    step();
    mem_bus.addr_ok = 0; mem_bus.data_ok = 1; mem_bus.rdata = 32'h0000_0044;
    #1;
    checks++; if (inst_bus.rdata !== 32'h44) begin errors++; $display("FAIL spur_final_rdata: got %h expected 44", inst_bus.rdata); end
    step();
    clear_inputs();
  endtask

  task automatic test_reset_in_resp();
    inst_bus.req = 1; inst_bus.addr = 32'h40; inst_bus.wdata = 32'h77;
    step();
    inst_bus.req = 0; mem_bus.addr_ok = 1;
    step();
    mem_bus.addr_ok = 0;
    inst_bus.req = 1;
    #1;
    resetn = 0; mem_bus.data_ok = 1; mem_bus.rdata = 32'hFFFF_FFFF;
    #1;
    checks++; if (inst_bus.data_ok !== 1'b0 || inst_bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_inst: got %b/%h expected 0/0", inst_bus.data_ok, inst_bus.rdata); end
    checks++; if (inst_bus.addr_ok !== 1'b0 || data_bus.addr_ok !== 1'b0) begin errors++; $display("FAIL rst_resp_addr_ok: got %b%b expected 00", inst_bus.addr_ok, data_bus.addr_ok); end
    checks++; if (mem_bus.req !== 1'b0 || mem_bus.addr !== 32'h0 || mem_bus.wdata !== 32'h0) begin errors++; $display("FAIL rst_resp_mem: got %b/%h/%h expected 0/0/0", mem_bus.req, mem_bus.addr, mem_bus.wdata); end
    step();
    resetn = 1; inst_bus.req = 0;
    #1;
    checks++; if (inst_bus.data_ok !== 1'b0 || data_bus.data_ok !== 1'b0) begin errors++; $display("FAIL rst_late_data_ok: got %b%b expected 00", inst_bus.data_ok, data_bus.data_ok); end
    step();
    mem_bus.data_ok = 0; inst_bus.req = 1; inst_bus.addr = 32'h80;
    #1;
    checks++; if (inst_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL rst_new_addr_ok: got %b expected 1", inst_bus.addr_ok); end
    step();
    inst_bus.req = 0; mem_bus.addr_ok = 1;
    #1;
    checks++; if (mem_bus.addr !== 32'h80) begin errors++; $display("FAIL rst_new_mem_addr: got %h expected 80", mem_bus.addr); end
    step();
    mem_bus.addr_ok = 0; mem_bus.data_ok = 1; mem_bus.rdata = 32'hCAFE_0080;
    #1;
    checks++; if (inst_bus.rdata !== 32'hCAFE_0080) begin errors++; $display("FAIL rst_new_rdata: got %h expected cafe0080", inst_bus.rdata); end
    step();
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_tie();
    test_single_inst_read();
    test_write_stall();
    test_spurious();
    test_reset_in_resp();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
